// File: rtl/hazard_unit_md_pkg.sv
// Shared definitions for the hazard unit with multi-cycle multiply/divide
// scoreboarding: default register-address width and forwarding-select codes.
package hazard_unit_md_pkg;

    localparam int REG_AW = 5;

    // Forwarding mux select for the EX-stage ALU operands
    localparam logic [1:0] FWD_RF = 2'b00;  // value from the register file
    localparam logic [1:0] FWD_W  = 2'b01;  // value from the writeback stage
    localparam logic [1:0] FWD_M  = 2'b10;  // value from the memory stage

    // Register 0 is hardwired to zero and never creates a dependency
    localparam logic [REG_AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/hazard_unit_md_md_scoreboard.sv
// Scoreboard for the single non-pipelined multiply/divide unit. Tracks
// occupancy, the cycles left until the result is written and its
// destination register. Issue and completion may coincide (back-to-back).
module md_scoreboard #(
    parameter int REG_AW     = 5,
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MdStartE,
    input  logic [REG_AW-1:0] WriteRegE,
    output logic              MdBusy,
    output logic              MdWriteback,
    output logic [REG_AW-1:0] MdWriteReg
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 1);

    logic              busyReg;
    logic [CNT_W-1:0]  cntReg;
    logic [REG_AW-1:0] destReg;

    // Issue reloads the scoreboard, otherwise count down and retire at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            busyReg <= 1'b0;
            cntReg  <= '0;
            destReg <= '0;
        end else if (MdStartE) begin
            busyReg <= 1'b1;
            cntReg  <= CNT_LOAD;
            destReg <= WriteRegE;
        end else if (busyReg) begin
            if (cntReg != '0) begin
                cntReg <= cntReg - 1'b1;
            end else begin
                busyReg <= 1'b0;
            end
        end
    end

    assign MdBusy      = busyReg;
    // The result lands during the last busy cycle, when the count has run out
    assign MdWriteback = busyReg && (cntReg == '0);
    // Destination stays visible after completion until the next issue
    assign MdWriteReg  = destReg;

endmodule

// File: rtl/hazard_unit_md.sv
// Hazard unit for the 5-stage pipeline: EX and branch forwarding, load-use
// and branch-operand stalls, plus RAW/structural stalls against the
// multi-cycle multiply/divide unit tracked by md_scoreboard.
module hazard_unit_md #(
    parameter int REG_AW     = hazard_unit_md_pkg::REG_AW,
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWriteE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MemtoRegM,
    input  logic              MemReadE,
    input  logic [REG_AW-1:0] WriteRegE,
    input  logic [REG_AW-1:0] WriteRegM,
    input  logic [REG_AW-1:0] WriteRegW,
    input  logic [REG_AW-1:0] RsE,
    input  logic [REG_AW-1:0] RtE,
    input  logic [REG_AW-1:0] RsD,
    input  logic [REG_AW-1:0] RtD,
    input  logic              BranchD,
    input  logic              MdOpD,
    input  logic              MdStartE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              ForwardAD,
    output logic              ForwardBD,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushE,
    output logic              MdBusy,
    output logic              MdWriteback,
    output logic [REG_AW-1:0] MdWriteReg
);

    import hazard_unit_md_pkg::*;

    md_scoreboard #(
        .REG_AW     (REG_AW),
        .MD_LATENCY (MD_LATENCY),
        .CNT_W      (CNT_W)
    ) u_md_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .MdStartE    (MdStartE),
        .WriteRegE   (WriteRegE),
        .MdBusy      (MdBusy),
        .MdWriteback (MdWriteback),
        .MdWriteReg  (MdWriteReg)
    );

    // Index 0 is the Rs operand, index 1 the Rt operand
    logic [1:0][REG_AW-1:0] srcE;
    logic [1:0][REG_AW-1:0] srcD;
    logic [1:0][1:0]        fwdE;
    logic [1:0]             fwdD;
    logic [1:0]             lwHit;
    logic [1:0]             brHit;
    logic [1:0]             rawHit;
    logic                   mdPending;
    logic                   lwStall;
    logic                   brStall;
    logic                   mdRaw;
    logic                   mdStruct;
    logic                   stall;

    assign srcE = {RtE, RsE};
    assign srcD = {RtD, RsD};

    // In the writeback cycle the result reaches the register file through the
    // W path (write-first), so only the cycles before it block a reader
    assign mdPending = MdBusy && !MdWriteback;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            // EX operand forwarding, youngest producer (M) wins over W
            assign fwdE[gi] = (RegWriteM && (WriteRegM != '0) && (WriteRegM == srcE[gi])) ? FWD_M :
                              (RegWriteW && (WriteRegW != '0) && (WriteRegW == srcE[gi])) ? FWD_W :
                              FWD_RF;

            // Branch comparator operand taken from the M-stage ALU result
            assign fwdD[gi] = RegWriteM && (srcD[gi] != '0) && (srcD[gi] == WriteRegM);

            assign lwHit[gi] = (WriteRegE == srcD[gi]);

            // Branch operand still being computed in E, or being loaded in M
            assign brHit[gi] = (RegWriteE && (WriteRegE != '0) && (WriteRegE == srcD[gi])) ||
                               (MemtoRegM && (WriteRegM != '0) && (WriteRegM == srcD[gi]));

            // Decode reads a register the MD unit is issuing to or still computing
            assign rawHit[gi] = (srcD[gi] != '0) &&
                                ((MdStartE && (WriteRegE == srcD[gi])) ||
                                 (mdPending && (MdWriteReg == srcD[gi])));
        end
    endgenerate

    assign ForwardAE = fwdE[0];
    assign ForwardBE = fwdE[1];
    assign ForwardAD = fwdD[0];
    assign ForwardBD = fwdD[1];

    assign lwStall  = MemReadE && (WriteRegE != '0) && (|lwHit);
    assign brStall  = BranchD && (|brHit);
    assign mdRaw    = |rawHit;
    // Only one MD op may be in flight; a second one waits in decode
    assign mdStruct = MdOpD && (mdPending || MdStartE);

    assign stall  = lwStall || brStall || mdRaw || mdStruct;
    assign StallF = stall;
    assign StallD = stall;
    assign FlushE = stall;

endmodule

// File: tb/tb_hazard_unit_md.sv
// Bench for hazard_unit_md: directed vectors with literal expectations plus a
// cycle-stamped reference model compared against the DUT on every cycle.
module tb_hazard_unit_md;

    localparam int AW     = 5;
    localparam int MD_LAT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          RegWriteE, RegWriteM, RegWriteW, MemtoRegM, MemReadE;
    logic [AW-1:0] WriteRegE, WriteRegM, WriteRegW, RsE, RtE, RsD, RtD;
    logic          BranchD, MdOpD, MdStartE;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          ForwardAD, ForwardBD, StallF, StallD, FlushE;
    logic          MdBusy, MdWriteback;
    logic [AW-1:0] MdWriteReg;

    int asserts = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    hazard_unit_md #(.REG_AW(AW), .MD_LATENCY(MD_LAT), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegM(MemtoRegM), .MemReadE(MemReadE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RsE(RsE), .RtE(RtE), .RsD(RsD), .RtD(RtD),
        .BranchD(BranchD), .MdOpD(MdOpD), .MdStartE(MdStartE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .MdBusy(MdBusy), .MdWriteback(MdWriteback), .MdWriteReg(MdWriteReg)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The MD op is described by the cycle it issued in: it is busy until
    // cycle issue+MD_LAT inclusive and writes back exactly in that cycle.
    int            cyc = 0;
    int            mIssue = 0;
    bit            mActive = 0;
    bit            mValid = 0;
    logic [AW-1:0] mDest = '0;

    always @(posedge clk) begin
        if (reset) begin
            mActive <= 0;
            mDest   <= '0;
            mValid  <= 1;
        end else if (MdStartE) begin
            mActive <= 1;
            mIssue  <= cyc;
            mDest   <= WriteRegE;
        end else if (mActive && cyc == mIssue + MD_LAT) begin
            mActive <= 0;
        end
        cyc <= cyc + 1;
    end

    function automatic logic [1:0] modelFwdE(input logic [AW-1:0] src);
        if (RegWriteM && WriteRegM != 0 && WriteRegM == src) return 2'd2;
        if (RegWriteW && WriteRegW != 0 && WriteRegW == src) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic readsReg(input logic [AW-1:0] r);
        return r != 0 && (r == RsD || r == RtD);
    endfunction

    function automatic logic modelStall(input logic busyNow, input logic wbNow);
        logic waiting, lw, br, raw, st;
        waiting = busyNow && !wbNow;
        lw  = MemReadE && readsReg(WriteRegE);
        br  = BranchD && ((RegWriteE && readsReg(WriteRegE)) || (MemtoRegM && readsReg(WriteRegM)));
        raw = (MdStartE && readsReg(WriteRegE)) || (waiting && readsReg(mDest));
        st  = MdOpD && (waiting || MdStartE);
        return lw || br || raw || st;
    endfunction

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (mValid) begin
            logic eBusy, eWb, eStall;
            eBusy  = mActive;
            eWb    = mActive && (cyc == mIssue + MD_LAT);
            eStall = modelStall(eBusy, eWb);
            chk("m_ForwardAE", ForwardAE, modelFwdE(RsE));
            chk("m_ForwardBE", ForwardBE, modelFwdE(RtE));
            chk("m_ForwardAD", ForwardAD, RegWriteM && RsD != 0 && RsD == WriteRegM);
            chk("m_ForwardBD", ForwardBD, RegWriteM && RtD != 0 && RtD == WriteRegM);
            chk("m_StallF", StallF, eStall);
            chk("m_StallD", StallD, eStall);
            chk("m_FlushE", FlushE, eStall);
            chk("m_MdBusy", MdBusy, eBusy);
            chk("m_MdWriteback", MdWriteback, eWb);
            chk("m_MdWriteReg", MdWriteReg, mDest);
            chk("no_issue_while_busy", MdStartE && MdBusy && !MdWriteback, 1'b0);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic clr();
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegM = 0; MemReadE = 0;
        WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
        RsE = 0; RtE = 0; RsD = 0; RtD = 0;
        BranchD = 0; MdOpD = 0; MdStartE = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        clr();
        reset = 1;
        tick(); tick();
        sample();
        chk("rst_MdBusy", MdBusy, 0);
        chk("rst_MdWriteback", MdWriteback, 0);
        chk("rst_MdWriteReg", MdWriteReg, 0);
        tick();
        reset = 0;

        // 1: forwarding priority, then register 0
        RegWriteM = 1; WriteRegM = 8; RegWriteW = 1; WriteRegW = 8; RsE = 8; RtE = 9;
        sample();
        chk("t1_ForwardAE_M", ForwardAE, 2'b10);
        chk("t1_ForwardBE_RF", ForwardBE, 2'b00);
        tick();
        WriteRegM = 0; RsE = 0;
        sample();
        chk("t1_ForwardAE_zero", ForwardAE, 2'b00);
        tick();
        RsE = 8; RtE = 8;
        sample();
        chk("t1_ForwardAE_W", ForwardAE, 2'b01);
        tick();

        // 2: load-use
        clr(); MemReadE = 1; WriteRegE = 5; RsD = 5;
        sample();
        chk("t2_stall", StallF, 1);
        chk("t2_flush", FlushE, 1);
        tick();
        MemReadE = 0;
        sample();
        chk("t2_nostall", StallD, 0);
        tick();

        // 3: branch operand in E, then forwarded from M
        clr(); BranchD = 1; RegWriteE = 1; WriteRegE = 3; RtD = 3;
        sample();
        chk("t3_brstall", StallD, 1);
        tick();
        RegWriteE = 0; WriteRegE = 0; RegWriteM = 1; MemtoRegM = 0; WriteRegM = 3;
        sample();
        chk("t3_nostall", StallD, 0);
        chk("t3_ForwardBD", ForwardBD, 1);
        tick();

        // 4: MD RAW, reader of r10 held in decode
        clr(); MdStartE = 1; WriteRegE = 10; RsD = 10;
        sample();
        chk("t4_stall_t0", StallF, 1);
        tick();
        MdStartE = 0; WriteRegE = 0;
        for (int i = 1; i <= 3; i++) begin
            sample();
            chk("t4_stall_busy", StallF, 1);
            chk("t4_busy", MdBusy, 1);
            chk("t4_nowb", MdWriteback, 0);
            tick();
        end
        MdOpD = 1;
        sample();
        chk("t4_wb", MdWriteback, 1);
        chk("t4_wbreg", MdWriteReg, 10);
        chk("t4_nostall_wb", StallF, 0);
        tick();
        MdOpD = 0;
        sample();
        chk("t4_idle", MdBusy, 0);
        chk("t4_regheld", MdWriteReg, 10);
        tick();

        // 5: structural stall, then back-to-back issue at writeback
        clr(); MdStartE = 1; WriteRegE = 11;
        sample();
        tick();
        MdStartE = 0; WriteRegE = 0; MdOpD = 1;
        for (int i = 1; i <= 3; i++) begin
            sample();
            chk("t5_struct", StallD, 1);
            tick();
        end
        MdOpD = 0; MdStartE = 1; WriteRegE = 12;
        sample();
        chk("t5_wb1", MdWriteback, 1);
        chk("t5_wbreg1", MdWriteReg, 11);
        chk("t5_nostall", StallD, 0);
        tick();
        MdStartE = 0; WriteRegE = 0;
        for (int i = 5; i <= 7; i++) begin
            sample();
            chk("t5_busy2", MdBusy, 1);
            chk("t5_nowb2", MdWriteback, 0);
            tick();
        end
        sample();
        chk("t5_wb2", MdWriteback, 1);
        chk("t5_wbreg2", MdWriteReg, 12);
        tick();

        // 6: reset abandons the op; dest 0 never stalls
        clr(); MdStartE = 1; WriteRegE = 7;
        tick();
        MdStartE = 0; WriteRegE = 0;
        tick();
        reset = 1;
        sample();
        chk("t6_busy_in_rst", MdBusy, 1);
        tick();
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("t6_busy_abandon", MdBusy, 0);
            chk("t6_nowb", MdWriteback, 0);
            chk("t6_reg0", MdWriteReg, 0);
            tick();
        end
        MdStartE = 1; WriteRegE = 0; RsD = 0; RtD = 0;
        sample();
        chk("t6_zero_nostall", StallF, 0);
        tick();
        MdStartE = 0;
        sample();
        chk("t6_zero_busy", MdBusy, 1);
        chk("t6_zero_nostall2", StallF, 0);
        for (int i = 0; i < 6; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
